// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A-compatible PIC control logic.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    ACK1,
    WAIT2,
    ACK2
  } state_t;

  // OCW2 R/SL/EOI field encodings that request an ISR clear
  localparam logic [2:0] NON_SPECIFIC_EOI           = 3'b001;
  localparam logic [2:0] SPECIFIC_EOI               = 3'b011;
  localparam logic [2:0] ROTATE_ON_NON_SPECIFIC_EOI = 3'b101;
  localparam logic [2:0] ROTATE_ON_SPECIFIC_EOI     = 3'b111;

  localparam logic [2:0] SPURIOUS_INDEX = 3'd7;

  function automatic logic is_non_specific_eoi(input logic [2:0] code);
    return (code == NON_SPECIFIC_EOI) || (code == ROTATE_ON_NON_SPECIFIC_EOI);
  endfunction

  function automatic logic is_specific_eoi(input logic [2:0] code);
    return (code == SPECIFIC_EOI) || (code == ROTATE_ON_SPECIFIC_EOI);
  endfunction

endpackage

// File: rtl/pic_inta_sequencer_if.sv
// Resolver, register-file and CPU-bus signals seen by the INTA sequencer.
interface pic_inta_sequencer_if #(
  parameter int VEC_BASE_W = 5
) ();
  logic                  inta_n;
  logic                  int_request;
  logic [2:0]            serviced_index;
  logic [2:0]            zero_level_priority;
  logic [7:0]            isr_reg;
  logic [VEC_BASE_W-1:0] icw2_base;
  logic                  aeoi_en;
  logic                  ocw2_wr;
  logic [7:0]            ocw2;
  logic                  int_out;
  logic                  freeze;
  logic                  int_request_ack;
  logic                  isr_set;
  logic                  irr_clr;
  logic [2:0]            isr_index;
  logic                  isr_clr;
  logic [2:0]            isr_clr_index;
  logic [7:0]            data_out;
  logic                  data_oe;

  modport master (
    output inta_n, int_request, serviced_index, zero_level_priority, isr_reg,
           icw2_base, aeoi_en, ocw2_wr, ocw2,
    input  int_out, freeze, int_request_ack, isr_set, irr_clr, isr_index,
           isr_clr, isr_clr_index, data_out, data_oe
  );

  modport slave (
    input  inta_n, int_request, serviced_index, zero_level_priority, isr_reg,
           icw2_base, aeoi_en, ocw2_wr, ocw2,
    output int_out, freeze, int_request_ack, isr_set, irr_clr, isr_index,
           isr_clr, isr_clr_index, data_out, data_oe
  );
endinterface

// File: rtl/pic_isr_priority_scan.sv
// Finds the highest-priority set ISR bit, where priority starts at
// zero_level_priority and increases in IR number modulo 8.
module pic_isr_priority_scan (
  input  logic [7:0] isr_reg,
  input  logic [2:0] zero_level_priority,
  output logic [2:0] first_index,
  output logic       found
);
  logic [15:0] doubled;
  logic [7:0]  rotated;
  logic [2:0]  offset;

  always_comb begin
    doubled = {isr_reg, isr_reg} >> zero_level_priority;
    rotated = doubled[7:0];
    offset  = 3'd0;
    // Descending scan so the lowest rotated position wins
    for (int i = 7; i >= 0; i--) begin
      if (rotated[i]) offset = 3'(i);
    end
    found       = |rotated;
    first_index = zero_level_priority + offset;
  end
endmodule

// File: rtl/pic_inta_sequencer.sv
// 8086-mode INT/INTA sequencer for the 8259A-compatible PIC, including
// OCW2 EOI decode and automatic-EOI ISR clearing.
module pic_inta_sequencer
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int VEC_BASE_W  = 5
) (
  input logic                clk,
  input logic                rst_n,
  pic_inta_sequencer_if.slave bus
);
  logic [SYNC_STAGES-1:0] inta_sync;
  logic                   inta_s;
  logic                   inta_prev;
  logic                   inta_fall;
  logic                   inta_rise;

  state_t     state;
  logic [2:0] vec_index;
  logic       spurious;

  logic       eoi_pend_vld;
  logic [2:0] eoi_pend_idx;
  logic       eoi_req;
  logic [2:0] eoi_idx;
  logic       aeoi_fire;

  logic       scan_found;
  logic [2:0] scan_index;

  pic_isr_priority_scan u_scan (
    .isr_reg             (bus.isr_reg),
    .zero_level_priority (bus.zero_level_priority),
    .first_index         (scan_index),
    .found               (scan_found)
  );

  // inta_n is asynchronous to clk; edges are detected after the synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inta_sync <= '1;
      inta_prev <= 1'b1;
    end else begin
      inta_sync <= {inta_sync[SYNC_STAGES-2:0], bus.inta_n};
      inta_prev <= inta_s;
    end
  end

  assign inta_s    = inta_sync[SYNC_STAGES-1];
  assign inta_fall = inta_prev & ~inta_s;
  assign inta_rise = ~inta_prev & inta_s;

  always_comb begin
    eoi_req = 1'b0;
    eoi_idx = scan_index;
    if (bus.ocw2_wr) begin
      if (is_non_specific_eoi(bus.ocw2[7:5])) begin
        eoi_req = scan_found;
      end else if (is_specific_eoi(bus.ocw2[7:5])) begin
        eoi_req = 1'b1;
        eoi_idx = bus.ocw2[2:0];
      end
    end
  end

  assign aeoi_fire = (state == ACK2) && inta_rise && bus.aeoi_en && !spurious;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      vec_index           <= 3'd0;
      spurious            <= 1'b0;
      eoi_pend_vld        <= 1'b0;
      eoi_pend_idx        <= 3'd0;
      bus.int_out         <= 1'b0;
      bus.freeze          <= 1'b0;
      bus.int_request_ack <= 1'b0;
      bus.isr_set         <= 1'b0;
      bus.irr_clr         <= 1'b0;
      bus.isr_index       <= 3'd0;
      bus.isr_clr         <= 1'b0;
      bus.isr_clr_index   <= 3'd0;
      bus.data_out        <= 8'd0;
      bus.data_oe         <= 1'b0;
    end else begin
      bus.int_request_ack <= 1'b0;
      bus.isr_set         <= 1'b0;
      bus.irr_clr         <= 1'b0;
      bus.isr_clr         <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.int_request) begin
            state       <= PEND;
            bus.int_out <= 1'b1;
          end
        end
        PEND: begin
          if (inta_fall) begin
            // A request withdrawn before the first INTA is answered as IR7
            state               <= ACK1;
            bus.freeze          <= 1'b1;
            bus.int_out         <= 1'b0;
            bus.int_request_ack <= 1'b1;
            spurious            <= !bus.int_request;
            vec_index           <= bus.int_request ? bus.serviced_index : SPURIOUS_INDEX;
            bus.isr_index       <= bus.int_request ? bus.serviced_index : SPURIOUS_INDEX;
            bus.isr_set         <= bus.int_request;
            bus.irr_clr         <= bus.int_request;
          end else begin
            bus.int_out <= bus.int_request;
          end
        end
        ACK1: begin
          if (inta_rise) state <= WAIT2;
        end
        WAIT2: begin
          if (inta_fall) begin
            state        <= ACK2;
            bus.data_out <= {bus.icw2_base[VEC_BASE_W-1:0], vec_index};
            bus.data_oe  <= 1'b1;
          end
        end
        ACK2: begin
          if (inta_rise) begin
            state       <= IDLE;
            bus.data_oe <= 1'b0;
            bus.freeze  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // One ISR clear per cycle: AEOI first, then a deferred EOI, then a fresh EOI
      if (aeoi_fire) begin
        bus.isr_clr       <= 1'b1;
        bus.isr_clr_index <= vec_index;
        if (eoi_req) begin
          eoi_pend_vld <= 1'b1;
          eoi_pend_idx <= eoi_idx;
        end
      end else if (eoi_pend_vld) begin
        bus.isr_clr       <= 1'b1;
        bus.isr_clr_index <= eoi_pend_idx;
        eoi_pend_vld      <= eoi_req;
        eoi_pend_idx      <= eoi_idx;
      end else if (eoi_req) begin
        bus.isr_clr       <= 1'b1;
        bus.isr_clr_index <= eoi_idx;
      end
    end
  end
endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Scoreboard bench for pic_inta_sequencer: stimulus queues expected ISR
// strobes and vector bytes, a negedge monitor matches them against the DUT.
module tb_pic_inta_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pic_inta_sequencer_if #(.VEC_BASE_W(5)) bus ();

  pic_inta_sequencer #(.SYNC_STAGES(2), .VEC_BASE_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int passed = 0;
  int exp_set_q[$];
  int exp_clr_q[$];
  int exp_vec_q[$];
  bit oe_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe / vector presentation must match the queued expectation
  always @(negedge clk) begin
    if (!rst_n) begin
      oe_prev = 1'b0;
    end else begin
      if (bus.isr_set) begin
        check("irr_clr_with_isr_set", int'(bus.irr_clr), 1);
        if (exp_set_q.size() == 0) begin
          checks++;
          $display("FAIL isr_set_unexpected: got index %0d, required no pulse", bus.isr_index);
        end else check("isr_set_index", int'(bus.isr_index), exp_set_q.pop_front());
      end
      if (bus.isr_clr) begin
        if (exp_clr_q.size() == 0) begin
          checks++;
          $display("FAIL isr_clr_unexpected: got index %0d, required no pulse", bus.isr_clr_index);
        end else check("isr_clr_index", int'(bus.isr_clr_index), exp_clr_q.pop_front());
      end
      if (bus.data_oe && !oe_prev) begin
        if (exp_vec_q.size() == 0) begin
          checks++;
          $display("FAIL vector_unexpected: got 0x%0h, required no drive", bus.data_out);
        end else check("vector_byte", int'(bus.data_out), exp_vec_q.pop_front());
      end
      oe_prev = bus.data_oe;
    end
  end

  task automatic inta_cycle(input logic [2:0] idx, input logic [4:0] base, input bit aeoi,
                            input bit spur, input bit collide, input bit reset_mid);
    logic [2:0] vidx;
    logic [7:0] vec;
    bit seen;
    vidx = spur ? 3'd7 : idx;
    vec  = {base, vidx};
    bus.serviced_index = idx;
    bus.icw2_base      = base;
    bus.aeoi_en        = aeoi;
    bus.int_request    = 1'b1;
    if (!spur) exp_set_q.push_back(int'(idx));
    exp_vec_q.push_back(int'(vec));
    if (aeoi && !spur && !reset_mid) exp_clr_q.push_back(int'(idx));
    if (collide) exp_clr_q.push_back(2);

    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge clk);
      seen = bus.int_out;
    end
    check("int_out_assert", int'(seen), 1);
    tick(1);
    if (spur) begin
      bus.int_request = 1'b0;
      tick(2);
      @(negedge clk);
      check("int_out_drop_on_withdraw", int'(bus.int_out), 0);
      tick(1);
    end

    bus.inta_n = 1'b0;
    tick(4);
    @(negedge clk);
    check("freeze_after_first_fall", int'(bus.freeze), 1);
    check("int_out_after_first_fall", int'(bus.int_out), 0);
    tick(1);
    bus.int_request = 1'b0;
    bus.inta_n = 1'b1;
    tick(3);
    bus.inta_n = 1'b0;
    tick(4);
    @(negedge clk);
    check("data_oe_second_low", int'(bus.data_oe), 1);
    check("data_out_second_low", int'(bus.data_out), int'(vec));

    if (reset_mid) begin
      #1 rst_n = 1'b0;
      #1;
      check("reset_async_data_oe", int'(bus.data_oe), 0);
      check("reset_async_freeze", int'(bus.freeze), 0);
      check("reset_async_int_out", int'(bus.int_out), 0);
      bus.inta_n = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      return;
    end

    tick(1);
    bus.inta_n = 1'b1;
    if (collide) begin
      tick(2);
      bus.ocw2    = 8'h62;
      bus.ocw2_wr = 1'b1;
      tick(1);
      bus.ocw2_wr = 1'b0;
    end
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = !bus.freeze;
    end
    check("freeze_release", int'(seen), 1);
    check("aeoi_clr_at_release", int'(bus.isr_clr), int'(aeoi && !spur));
    check("data_oe_release", int'(bus.data_oe), 0);
    check("data_out_hold", int'(bus.data_out), int'(vec));
    @(negedge clk);
    check("isr_clr_after_release", int'(bus.isr_clr), int'(collide));
    tick(3);
  endtask

  task automatic eoi(input string name, input logic [7:0] isr, input logic [2:0] zlp,
                     input logic [7:0] cmd, input bit pulse, input logic [2:0] idx);
    bus.isr_reg             = isr;
    bus.zero_level_priority = zlp;
    bus.ocw2                = cmd;
    if (pulse) exp_clr_q.push_back(int'(idx));
    bus.ocw2_wr = 1'b1;
    tick(1);
    bus.ocw2_wr = 1'b0;
    @(negedge clk);
    check(name, int'(bus.isr_clr), int'(pulse));
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n                   = 1'b0;
    bus.inta_n              = 1'b1;
    bus.int_request         = 1'b0;
    bus.serviced_index      = 3'd0;
    bus.zero_level_priority = 3'd0;
    bus.isr_reg             = 8'h00;
    bus.icw2_base           = 5'd0;
    bus.aeoi_en             = 1'b0;
    bus.ocw2_wr             = 1'b0;
    bus.ocw2                = 8'h00;
    tick(3);
    @(negedge clk);
    check("reset_int_out", int'(bus.int_out), 0);
    check("reset_freeze", int'(bus.freeze), 0);
    check("reset_data_oe", int'(bus.data_oe), 0);
    check("reset_data_out", int'(bus.data_out), 0);
    check("reset_isr_set", int'(bus.isr_set), 0);
    check("reset_isr_clr", int'(bus.isr_clr), 0);
    check("reset_ack", int'(bus.int_request_ack), 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // normal, AEOI, spurious, collision
    inta_cycle(3'd3, 5'b01000, 1'b0, 1'b0, 1'b0, 1'b0);
    inta_cycle(3'd6, 5'b01000, 1'b1, 1'b0, 1'b0, 1'b0);
    inta_cycle(3'd3, 5'b10101, 1'b1, 1'b1, 1'b0, 1'b0);
    inta_cycle(3'd6, 5'b01000, 1'b1, 1'b0, 1'b1, 1'b0);

    eoi("ns_eoi_zlp5",      8'h90, 3'd5, 8'h20, 1'b1, 3'd7);
    eoi("ns_eoi_zlp0",      8'h90, 3'd0, 8'h20, 1'b1, 3'd4);
    eoi("ns_eoi_empty",     8'h00, 3'd2, 8'h20, 1'b0, 3'd0);
    eoi("rot_ns_eoi_wrap",  8'h05, 3'd3, 8'hA0, 1'b1, 3'd0);
    eoi("sp_eoi_uncond",    8'h00, 3'd0, 8'h65, 1'b1, 3'd5);
    eoi("rot_sp_eoi",       8'hFF, 3'd4, 8'hE3, 1'b1, 3'd3);
    eoi("other_code_010",   8'hFF, 3'd0, 8'h40, 1'b0, 3'd0);
    eoi("other_code_110",   8'hFF, 3'd0, 8'hC1, 1'b0, 3'd0);

    // reset while the vector is on the bus, then a fresh full cycle
    inta_cycle(3'd2, 5'b01000, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("post_reset_idle_int_out", int'(bus.int_out), 0);
    check("post_reset_idle_freeze", int'(bus.freeze), 0);
    tick(1);
    inta_cycle(3'd1, 5'b01000, 1'b0, 1'b0, 1'b0, 1'b0);

    tick(5);
    check("set_queue_drained", exp_set_q.size(), 0);
    check("clr_queue_drained", exp_clr_q.size(), 0);
    check("vec_queue_drained", exp_vec_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/pic_inta_sequencer.md
Name: pic_inta_sequencer

Overview:
- Control-logic sequencer for the 8259A-compatible PIC, 8086 mode only.
- Takes the priority resolver's interrupt request and drives INT to the CPU.
- Runs the two-pulse INTA cycle: freezes the resolver, sets ISR, clears IRR and places the vector byte on the data bus.
- Also decodes OCW2 EOI commands into single-cycle ISR-clear strobes, including AEOI.

Parameters:
SYNC_STAGES, 2, synchronizer flops on inta_n (>=2)
VEC_BASE_W, 5, width of ICW2 vector base field (T7..T3)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
inta_n  in  1  CPU interrupt acknowledge, asynchronous, active low
int_request  in  1  resolver request (level)
serviced_index  in  3  resolver's winning IR index
zero_level_priority  in  3  resolver's current highest-priority IR position
isr_reg  in  8  current ISR contents
icw2_base  in  VEC_BASE_W  vector base T7..T3
aeoi_en  in  1  automatic EOI mode from ICW4
ocw2_wr  in  1  one-cycle strobe, ocw2 valid
ocw2  in  8  OCW2 byte (R,SL,EOI = bits 7:5; L2..L0 = bits 2:0)
int_out  out  1  INT to CPU
freeze  out  1  holds resolver inputs stable
int_request_ack  out  1  one-cycle ack to the resolver
isr_set  out  1  one-cycle strobe: set ISR[isr_index]
irr_clr  out  1  one-cycle strobe: clear IRR[isr_index]
isr_index  out  3  index for isr_set/irr_clr
isr_clr  out  1  one-cycle strobe: clear ISR[isr_clr_index]
isr_clr_index  out  3  index for isr_clr
data_out  out  8  vector byte
data_oe  out  1  data bus drive enable

Behaviour:
- Reset: all outputs 0, state IDLE, synchronizer flops 1 (inta high), latched index 0.
- inta_n passes through SYNC_STAGES flops. Fall = sync value goes 1->0; rise = 0->1. Fall/rise are each one-cycle events.
- States: IDLE, PEND, ACK1, WAIT2, ACK2.
- IDLE: when int_request=1, go to PEND and set int_out=1 on the next cycle.
- PEND: on inta fall:
  - Go to ACK1 and assert freeze.
  - Latch serviced_index, or 7 if int_request=0 (spurious).
  - Deassert int_out.
  - Pulse int_request_ack.
  - Non-spurious: pulse isr_set and irr_clr in the same cycle, with isr_index = latched index.
  - Spurious: no isr_set or irr_clr; vector index is 7.
- PEND, int_request drops before any inta fall: int_out is deasserted; state stays PEND.
- ACK1: on inta rise, go to WAIT2.
- WAIT2: on inta fall, go to ACK2. data_out = {icw2_base, latched index}, data_oe=1 from the next cycle.
- ACK2: data_oe stays 1 while inta is low. On inta rise:
  - data_oe=0 and freeze=0; data_out holds its value.
  - If aeoi_en and not spurious: pulse isr_clr with the latched index.
  - Go to IDLE. A new int_out can assert at earliest 2 cycles after the rise.
- EOI decode on ocw2_wr, bits 7:5:
  - 001 or 101 (non-specific): pulse isr_clr for the first set bit of isr_reg, scanning from zero_level_priority upward modulo 8. If isr_reg=0, no pulse.
  - 011 or 111 (specific): pulse isr_clr for ocw2[2:0], unconditionally.
  - Other codes: no action.
  - isr_clr fires one cycle after ocw2_wr.
- Collision: OCW2 EOI and AEOI clear in the same cycle. The AEOI clear is issued first; the EOI clear is delayed one cycle through a one-entry pending register. A further ocw2_wr while that register is full overwrites it.
- Reset in any state: immediate return to IDLE; data_oe, freeze and int_out drop asynchronously.
- Index arithmetic is 3-bit and wraps 7->0.

Decomposition:
- Shared package pic_pkg:
  - State enum.
  - OCW2 code constants: NON_SPECIFIC_EOI=001, SPECIFIC_EOI=011, ROTATE_ON_NON_SPECIFIC_EOI=101, ROTATE_ON_SPECIFIC_EOI=111.
  - SPURIOUS_INDEX=7.
- One sub-module: pic_isr_priority_scan. Combinational; rotates isr_reg by zero_level_priority and returns the first-set index plus a valid flag. Reusable by the resolver.

Test Plan:
- Normal INTA: int_request=1, serviced_index=3, icw2_base=5'b01000; pulse inta_n twice -> int_out high before the first fall; isr_set/irr_clr at index 3 on the first fall; data_out=8'h43 with data_oe=1 during the second low; freeze drops after the second rise.
- AEOI: aeoi_en=1, index 6 -> isr_clr with isr_clr_index=6 exactly one cycle after the second inta rise; no ISR clear without aeoi_en.
- Spurious: int_request drops after int_out but before the first fall -> no isr_set; data_out={base,3'b111}.
- Non-specific EOI: isr_reg=8'b1001_0000, zero_level_priority=5 -> isr_clr index 7; with zero_level_priority=0 -> index 4; with isr_reg=0 -> no pulse.
- Specific EOI plus collision: ocw2=8'b0110_0010 written on the same cycle as the AEOI clear of index 6 -> isr_clr at index 6, then index 2 on the next cycle.
- Reset mid-ACK2: rst_n low while data_oe=1 -> data_oe, freeze and int_out go to 0 immediately; after release, state is IDLE and a new request runs a full cycle.
